countdown_timer_param: RTL and testbench

//   Parametrised, loadable down-counter timer for irrigation-cycle durations.
//   It is the successor to the fixed 4-bit preset/button countdown, with

---
 rtl/countdown_timer_param.sv | 118 +++++++++++
 tb/tb_countdown_timer_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_param.sv
// Loadable down-counter timer for irrigation-cycle durations.
// Clamped preset, start/abort control, tick-gated decrement, one-shot or
// auto-reload at terminal count, registered terminal pulse and status flags.
module countdown_timer_param #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             abort,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             done,
    output logic             running,
    output logic             expired
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic [WIDTH-1:0] q_next;
    logic             done_next;
    logic [WIDTH-1:0] load_clamped;

    // Presets above the legal maximum saturate rather than wrap.
    assign load_clamped = (load_value > MAX_Q) ? MAX_Q : load_value;

    // State register; status flags are decoded from the next state so they
    // line up with the registered state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == RUN);
            expired <= (state_next == DONE);
        end
    end

    // Datapath registers: count, reload preset and terminal pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q          <= '0;
            reload_reg <= '0;
            done       <= 1'b0;
        end else begin
            q          <= q_next;
            reload_reg <= reload_next;
            done       <= done_next;
        end
    end

    // Next-state and datapath decisions; priority is load > abort > start > count.
    always_comb begin
        state_next  = state;
        q_next      = q;
        reload_next = reload_reg;
        done_next   = 1'b0;

        if (load) begin
            q_next      = load_clamped;
            reload_next = load_clamped;
            state_next  = IDLE;
        end else if (abort) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && (q != '0)) begin
                        state_next = RUN;
                    end
                end
                DONE: begin
                    if (start && (reload_reg != '0)) begin
                        q_next     = reload_reg;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    // A zero count while running is recovered silently.
                    if (q == '0) begin
                        state_next = DONE;
                    end else if (enable) begin
                        if (q == ONE_Q) begin
                            done_next = 1'b1;
                            if (auto_reload) begin
                                q_next = reload_reg;
                            end else begin
                                q_next     = '0;
                                state_next = DONE;
                            end
                        end else begin
                            q_next = q - ONE_Q;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer_param.sv
// Directed bench for countdown_timer_param with hand-computed expectations.
module tb_countdown_timer_param;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned MAX_VAL = 9;

    logic             clock;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             abort;
    logic             enable;
    logic             auto_reload;
    logic [WIDTH-1:0] q;
    logic             done;
    logic             running;
    logic             expired;

    int checks;
    int errors;

    countdown_timer_param #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .start       (start),
        .abort       (abort),
        .enable      (enable),
        .auto_reload (auto_reload),
        .q           (q),
        .done        (done),
        .running     (running),
        .expired     (expired)
    );

    // 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input int eq, input int edone,
                             input int erun, input int eexp);
        check({tag, ".q"},       32'(q),       32'(eq));
        check({tag, ".done"},    32'(done),    32'(edone));
        check({tag, ".running"}, 32'(running), 32'(erun));
        check({tag, ".expired"}, 32'(expired), 32'(eexp));
    endtask

    int t4_q    [12] = '{2, 2, 1, 1, 3, 3, 2, 2, 1, 1, 3, 3};
    int t4_done [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    int t2_q    [4]  = '{3, 2, 1, 0};

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        load        = 1'b0;
        load_value  = '0;
        start       = 1'b0;
        abort       = 1'b0;
        enable      = 1'b0;
        auto_reload = 1'b0;

        tick();
        check_out("reset", 0, 0, 0, 0);
        reset = 1'b0;
        tick();
        check_out("post_reset", 0, 0, 0, 0);

        // T2: one-shot countdown from 4.
        load_value = 4'd4; load = 1'b1;
        tick();
        check_out("t2_load", 4, 0, 0, 0);
        load = 1'b0; start = 1'b1; enable = 1'b1;
        tick();
        check_out("t2_start", 4, 0, 1, 0);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out($sformatf("t2_cnt%0d", i), t2_q[i], (i == 3) ? 1 : 0,
                      (i == 3) ? 0 : 1, (i == 3) ? 1 : 0);
        end
        tick();
        check_out("t2_after", 0, 0, 0, 1);
        // Start from DONE reloads the preset.
        enable = 1'b0; start = 1'b1;
        tick();
        check_out("t2_restart", 4, 0, 1, 0);
        start = 1'b0;

        // T3: clamp and start-with-zero.
        load_value = 4'd15; load = 1'b1;
        tick();
        check_out("t3_clamp", 9, 0, 0, 0);
        load_value = 4'd0;
        tick();
        check_out("t3_zero", 0, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        tick();
        check_out("t3_start0", 0, 0, 0, 0);
        start = 1'b0;

        // T4: auto-reload with tick every second cycle.
        auto_reload = 1'b1; load_value = 4'd3; load = 1'b1;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        check_out("t4_start", 3, 0, 1, 0);
        for (int i = 0; i < 12; i++) begin
            enable = (i % 2 == 0);
            start  = (i == 1);
            tick();
            check_out($sformatf("t4_c%0d", i), t4_q[i], t4_done[i], 1, 0);
        end
        start = 1'b0; enable = 1'b0; abort = 1'b1; auto_reload = 1'b0;
        tick();
        check_out("t4_abort", 3, 0, 0, 0);
        abort = 1'b0;

        // T5: abort mid-count then resume.
        load_value = 4'd5; load = 1'b1;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; enable = 1'b1;
        tick();
        tick();
        check_out("t5_two_ticks", 3, 0, 1, 0);
        enable = 1'b0; abort = 1'b1;
        tick();
        check_out("t5_abort", 3, 0, 0, 0);
        abort = 1'b0; start = 1'b1;
        tick();
        check_out("t5_resume", 3, 0, 1, 0);
        start = 1'b0; enable = 1'b1;
        tick();
        check_out("t5_dec", 2, 0, 1, 0);

        // T6: load collides with terminal count.
        tick();
        check_out("t6_at_one", 1, 0, 1, 0);
        load_value = 4'd7; load = 1'b1;
        tick();
        check_out("t6_load_wins", 7, 0, 0, 0);
        load = 1'b0; enable = 1'b0;
        tick();
        check_out("t6_load_nodone", 7, 0, 0, 0);
        // Abort collides with terminal count.
        start = 1'b1;
        tick();
        start = 1'b0; enable = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check_out("t6_at_one_b", 1, 0, 1, 0);
        abort = 1'b1;
        tick();
        check_out("t6_abort_wins", 1, 0, 0, 0);
        abort = 1'b0; enable = 1'b0;
        tick();
        check_out("t6_abort_nodone", 1, 0, 0, 0);

        // T1: asynchronous reset mid-run.
        load_value = 4'd5; load = 1'b1;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check_out("t1_pre", 5, 0, 1, 0);
        #3;
        reset = 1'b1;
        #1;
        check_out("t1_async", 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        check_out("t1_start_after_reset", 0, 0, 0, 0);
        start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
